// File: rtl/dsp_nco_pkg.sv
// Shared constants for the NCO sine-table path.
package dsp_nco_pkg;

   localparam int unsigned DEF_ADDR_WIDTH  = 10;
   localparam int unsigned DEF_DATA_WIDTH  = 16;
   localparam int unsigned DEF_PHASE_WIDTH = 32;

   // Read latency of dsp_nco_rom with and without its output register.
   localparam int unsigned ROM_LAT_COMB_OUT = 1;
   localparam int unsigned ROM_LAT_REG_OUT  = 2;

   function automatic int unsigned rom_lat_for(input bit reg_out);
      return reg_out ? ROM_LAT_REG_OUT : ROM_LAT_COMB_OUT;
   endfunction

endpackage

// File: rtl/dsp_nco_sched_fifo.sv
// Small synchronous FIFO for returned {channel, sample} pairs; count feeds the
// scheduler's credit check.
module dsp_nco_sched_fifo #(
   parameter int unsigned WIDTH = 18,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             not_empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign not_empty = (count != '0);
   assign do_pop    = pop && not_empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push   = push && ((count != CW'(DEPTH)) || do_pop);
   assign head      = mem[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= next_ptr(wr_ptr);
         end
         if (do_pop) rd_ptr <= next_ptr(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/dsp_nco_rom_sched.sv
// Shares one sine ROM between N_CH phase accumulators: round-robin issue under
// a credit limit, a tag pipe matching ROM latency, and a buffered output.
module dsp_nco_rom_sched
   import dsp_nco_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
   parameter int unsigned ROM_LAT     = ROM_LAT_COMB_OUT,
   parameter int unsigned FIFO_DEPTH  = 4,
   localparam int unsigned CH_W       = $clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_ch,
   input  logic [PHASE_WIDTH-1:0] cfg_inc,
   input  logic                   cfg_clr,
   input  logic [N_CH-1:0]        ch_en,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_dout,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data,
   output logic [CH_W-1:0]        m_ch,
   output logic                   busy
);

   localparam int unsigned FW = DATA_WIDTH + CH_W;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   logic [PHASE_WIDTH-1:0] phase [N_CH];
   logic [PHASE_WIDTH-1:0] inc   [N_CH];
   logic [CH_W-1:0]        rr_ptr;

   // Stage 0 lines up with rom_addr, stage ROM_LAT with valid rom_dout.
   logic [ROM_LAT:0]       tag_vld;
   logic [CH_W-1:0]        tag_ch [ROM_LAT+1];

   logic                   sel_found;
   logic [CH_W-1:0]        sel_ch;
   logic [31:0]            occupancy;
   logic                   issue;

   logic [CW-1:0]          fifo_count;
   logic                   fifo_not_empty;
   logic [FW-1:0]          fifo_head;

   // Round-robin pick: first enabled channel strictly after rr_ptr.
   always_comb begin
      logic [CH_W-1:0] cand;
      sel_found = 1'b0;
      sel_ch    = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= N_CH; k++) begin
         cand = CH_W'((32'(rr_ptr) + k) % N_CH);
         if (!sel_found && ch_en[cand]) begin
            sel_found = 1'b1;
            sel_ch    = cand;
         end
      end
   end

   // Credit rule: samples in flight plus buffered never exceed the FIFO depth.
   always_comb begin
      occupancy = 32'(fifo_count) + 32'($countones(tag_vld));
      issue     = sel_found && (occupancy < 32'(FIFO_DEPTH));
   end

   // Accumulators and increments; a clear is written last so it wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < int'(N_CH); c++) begin
            phase[c] <= '0;
            inc[c]   <= '0;
         end
      end else begin
         if (issue) phase[sel_ch] <= phase[sel_ch] + inc[sel_ch];
         if (cfg_we && (32'(cfg_ch) < N_CH)) begin
            inc[cfg_ch] <= cfg_inc;
            if (cfg_clr) phase[cfg_ch] <= '0;
         end
      end
   end

   // ROM address register and round-robin pointer, updated only on issue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rom_addr <= '0;
         rr_ptr   <= CH_W'(N_CH - 1);
      end else if (issue) begin
         rom_addr <= phase[sel_ch][PHASE_WIDTH-1 -: ADDR_WIDTH];
         rr_ptr   <= sel_ch;
      end
   end

   // Tag pipe tracking which channel each ROM read belongs to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_vld <= '0;
         for (int s = 0; s <= int'(ROM_LAT); s++) tag_ch[s] <= '0;
      end else begin
         tag_vld   <= {tag_vld[ROM_LAT-1:0], issue};
         tag_ch[0] <= sel_ch;
         for (int s = 1; s <= int'(ROM_LAT); s++) tag_ch[s] <= tag_ch[s-1];
      end
   end

   dsp_nco_sched_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_vld[ROM_LAT]),
      .push_data ({tag_ch[ROM_LAT], rom_dout}),
      .pop       (m_ready),
      .head      (fifo_head),
      .not_empty (fifo_not_empty),
      .count     (fifo_count)
   );

   assign m_valid        = fifo_not_empty;
   assign {m_ch, m_data} = fifo_head;
   assign busy           = (|tag_vld) || (fifo_count != '0);

endmodule

// File: tb/tb_dsp_nco_rom_sched.sv
// Scoreboard bench for dsp_nco_rom_sched with a 1-cycle behavioural ROM.
module tb_dsp_nco_rom_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_ch = '0;
   logic [31:0] cfg_inc = '0;
   logic        cfg_clr = 1'b0;
   logic [3:0]  ch_en = '0;
   logic [9:0]  rom_addr;
   logic [15:0] rom_dout;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [15:0] m_data;
   logic [1:0]  m_ch;
   logic        busy;

   typedef struct packed {
      logic [1:0]  ch;
      logic [15:0] data;
   } exp_t;

   exp_t exp_q [$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   dsp_nco_rom_sched #(
      .N_CH        (4),
      .ADDR_WIDTH  (10),
      .DATA_WIDTH  (16),
      .PHASE_WIDTH (32),
      .ROM_LAT     (1),
      .FIFO_DEPTH  (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_ch   (cfg_ch),
      .cfg_inc  (cfg_inc),
      .cfg_clr  (cfg_clr),
      .ch_en    (ch_en),
      .rom_addr (rom_addr),
      .rom_dout (rom_dout),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_ch     (m_ch),
      .busy     (busy)
   );

   // Distinct content per address stands in for the sine table.
   function automatic logic [15:0] rom_fn(input logic [9:0] a);
      return {a, 6'h15} ^ 16'h0f0f;
   endfunction

   always_ff @(posedge clk) rom_dout <= rom_fn(rom_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [1:0] ch, input int addr);
      exp_t e;
      e.ch   = ch;
      e.data = rom_fn(10'(addr));
      exp_q.push_back(e);
   endtask

   // Monitor: every accepted sample is matched against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_sample: got ch=%0d data=%h, expected none", m_ch, m_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (m_ch !== e.ch || m_data !== e.data) begin
               n_fail++;
               $display("FAIL sample: got ch=%0d data=%h, expected ch=%0d data=%h",
                        m_ch, m_data, e.ch, e.data);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic write_cfg(input logic [1:0] ch, input logic [31:0] inc, input logic clr);
      cfg_we  = 1'b1;
      cfg_ch  = ch;
      cfg_inc = inc;
      cfg_clr = clr;
      tick();
      cfg_we  = 1'b0;
      cfg_clr = 1'b0;
   endtask

   task automatic enable_for(input logic [3:0] en, input int edges);
      ch_en = en;
      repeat (edges) tick();
      ch_en = '0;
   endtask

   // Bounded wait for the scoreboard to empty and the DUT to go idle.
   task automatic wait_idle(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || busy) && cyc < 200) begin
         tick();
         cyc++;
      end
      check(name, {30'd0, busy, exp_q.size() != 0}, 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_m_ch", 32'(m_ch), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // 1: single-channel sweep across the table wrap
      write_cfg(2'd0, 32'h0040_0000, 1'b0);
      m_ready = 1'b1;
      for (int k = 0; k < 1030; k++) push_exp(2'd0, k % 1024);
      ch_en = 4'b0001;
      tick();
      check("t1_addr_e1", 32'(rom_addr), 32'd0);
      check("t1_valid_e1", 32'(m_valid), 32'd0);
      tick();
      check("t1_addr_e2", 32'(rom_addr), 32'd1);
      check("t1_valid_e2", 32'(m_valid), 32'd0);
      tick();
      check("t1_addr_e3", 32'(rom_addr), 32'd2);
      check("t1_valid_e3", 32'(m_valid), 32'd1);
      repeat (1027) tick();
      ch_en = '0;
      wait_idle("t1_idle");
      check("t1_addr_hold", 32'(rom_addr), 32'd5);

      // 2: round robin over all channels
      do_reset();
      for (int c = 0; c < 4; c++) write_cfg(2'(c), 32'(c + 1) << 22, 1'b0);
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++) push_exp(2'(c), k * (c + 1));
      enable_for(4'b1111, 12);
      wait_idle("t2_idle");

      // 3: backpressure fills the FIFO, then drain and resume
      do_reset();
      write_cfg(2'd0, 32'h0040_0000, 1'b0);
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) push_exp(2'd0, k);
      ch_en = 4'b0001;
      repeat (10) tick();
      check("t3_valid", 32'(m_valid), 32'd1);
      check("t3_busy", 32'(busy), 32'd1);
      check("t3_issues_stop", 32'(rom_addr), 32'd3);
      check("t3_head_data", 32'(m_data), 32'(rom_fn(10'd0)));
      repeat (3) tick();
      check("t3_head_stable", {14'd0, m_ch, m_data}, {16'd0, rom_fn(10'd0)});
      check("t3_still_stopped", 32'(rom_addr), 32'd3);
      ch_en   = '0;
      m_ready = 1'b1;
      wait_idle("t3_drain");
      for (int k = 4; k < 10; k++) push_exp(2'd0, k);
      enable_for(4'b0001, 6);
      wait_idle("t3_resume");

      // 4: partial enable mask, then all disabled
      do_reset();
      for (int c = 0; c < 4; c++) write_cfg(2'(c), 32'(c + 1) << 22, 1'b0);
      push_exp(2'd0, 0); push_exp(2'd2, 0); push_exp(2'd3, 0);
      push_exp(2'd0, 1); push_exp(2'd2, 3); push_exp(2'd3, 4);
      push_exp(2'd0, 2); push_exp(2'd2, 6);
      enable_for(4'b1101, 8);
      tick();
      tick();
      check("t4_busy_last_return", 32'(busy), 32'd1);
      tick();
      check("t4_busy_drained", 32'(busy), 32'd0);
      wait_idle("t4_idle");
      check("t4_addr_hold", 32'(rom_addr), 32'd6);

      // 5: clear collides with an issue of the same channel at addr 5
      do_reset();
      write_cfg(2'd2, 32'h0040_0000, 1'b0);
      for (int k = 0; k < 6; k++) push_exp(2'd2, k);
      push_exp(2'd2, 0);
      push_exp(2'd2, 1);
      ch_en = 4'b0100;
      repeat (5) tick();
      cfg_we  = 1'b1;
      cfg_ch  = 2'd2;
      cfg_inc = 32'h0040_0000;
      cfg_clr = 1'b1;
      tick();
      cfg_we  = 1'b0;
      cfg_clr = 1'b0;
      repeat (2) tick();
      ch_en = '0;
      wait_idle("t5_idle");
      check("t5_addr_after_clear", 32'(rom_addr), 32'd1);

      // 6: async reset with three buffered samples
      do_reset();
      write_cfg(2'd0, 32'h0040_0000, 1'b0);
      m_ready = 1'b0;
      ch_en   = 4'b0001;
      repeat (5) tick();
      check("t6_pre_valid", 32'(m_valid), 32'd1);
      #2;
      rst   = 1'b1;
      ch_en = '0;
      #1;
      check("t6_rst_valid", 32'(m_valid), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_addr", 32'(rom_addr), 32'd0);
      check("t6_rst_data", 32'(m_data), 32'd0);
      tick();
      rst     = 1'b0;
      m_ready = 1'b1;
      repeat (4) tick();
      check("t6_no_stale", 32'(m_valid), 32'd0);
      write_cfg(2'd0, 32'h0040_0000, 1'b0);
      for (int k = 0; k < 3; k++) push_exp(2'd0, k);
      enable_for(4'b0001, 3);
      wait_idle("t6_idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
